// File: rtl/data_sram_resp.sv
// rtl/data_sram_resp.sv - data-port responder: byte-lane RAM plus LED/switch/timer MMIO
module data_sram_resp #(
    parameter int          ADDR_W        = 10,
    parameter logic [31:0] TIMER_RST_CMP = 32'hFFFF_FFFF
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,
    input  logic [31:0] daddr,
    input  logic        dce,
    input  logic [3:0]  we,
    input  logic [31:0] din,
    output logic [31:0] dm,
    input  logic [15:0] switch,
    output logic [15:0] led,
    output logic        timer_int
);

    localparam logic [15:0] OFF_LED     = 16'hF000;
    localparam logic [15:0] OFF_SWITCH  = 16'hF004;
    localparam logic [15:0] OFF_COUNT   = 16'hF008;
    localparam logic [15:0] OFF_COMPARE = 16'hF00C;
    localparam logic [15:0] OFF_CTRL    = 16'hF010;

    logic [31:0] mem [2**ADDR_W];

    logic [31:0] dm_q, dm_d;
    logic [15:0] led_q, led_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        en_q, en_d;
    logic        pend_q, pend_d;
    logic        timer_int_q, timer_int_d;

    logic              mmio_sel;
    logic [15:0]       offset;
    logic [ADDR_W-1:0] ram_idx;
    logic              rd_access;
    logic              wr_access;
    logic              ram_we;
    logic              match;
    logic [31:0]       rd_data;
    logic [31:0]       led_wr;
    logic              unused_daddr;

    assign mmio_sel     = (daddr[31:16] == 16'hBFAF);
    assign offset       = daddr[15:0];
    assign ram_idx      = daddr[ADDR_W+1:2];
    assign rd_access    = dce && (we == 4'd0);
    assign wr_access    = dce && (we != 4'd0);
    assign unused_daddr = ^daddr;

    // Replace only the byte lanes whose enable bit is set
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

    // Read mux, write decode and timer next-state, all from pre-edge state
    always_comb begin
        dm_d        = dm_q;
        led_d       = led_q;
        count_d     = en_q ? count_q + 32'd1 : count_q;
        compare_d   = compare_q;
        en_d        = en_q;
        pend_d      = pend_q;
        ram_we      = 1'b0;
        rd_data     = 32'd0;
        led_wr      = merge_lanes({16'd0, led_q}, din, we);
        match       = en_q && (count_q == compare_q);
        timer_int_d = pend_q && en_q;

        if (mmio_sel) begin
            case (offset)
                OFF_LED:     rd_data = {16'd0, led_q};
                OFF_SWITCH:  rd_data = {16'd0, switch};
                OFF_COUNT:   rd_data = count_q;
                OFF_COMPARE: rd_data = compare_q;
                OFF_CTRL:    rd_data = {30'd0, pend_q, en_q};
                default:     rd_data = 32'd0;
            endcase
        end else begin
            rd_data = mem[ram_idx];
        end

        if (rd_access) begin
            dm_d = rd_data;
        end

        if (wr_access) begin
            if (mmio_sel) begin
                case (offset)
                    OFF_LED:     led_d     = led_wr[15:0];
                    OFF_COUNT:   count_d   = merge_lanes(count_q, din, we);
                    OFF_COMPARE: compare_d = merge_lanes(compare_q, din, we);
                    OFF_CTRL: begin
                        if (we[0]) begin
                            en_d = din[0];
                            if (din[1]) begin
                                pend_d = 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end else begin
                ram_we = 1'b1;
            end
        end

        // A match in the same cycle wins over write-1-to-clear
        if (match) begin
            pend_d = 1'b1;
        end
    end

    // Register state with synchronous active-low reset
    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            dm_q        <= 32'd0;
            led_q       <= 16'd0;
            count_q     <= 32'd0;
            compare_q   <= TIMER_RST_CMP;
            en_q        <= 1'b0;
            pend_q      <= 1'b0;
            timer_int_q <= 1'b0;
        end else begin
            dm_q        <= dm_d;
            led_q       <= led_d;
            count_q     <= count_d;
            compare_q   <= compare_d;
            en_q        <= en_d;
            pend_q      <= pend_d;
            timer_int_q <= timer_int_d;
        end
    end

    // RAM byte-lane writes; contents are not reset, but reset blocks the write
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst_n && ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[ram_idx][8*i +: 8] <= din[8*i +: 8];
                end
            end
        end
    end

    assign dm        = dm_q;
    assign led       = led_q;
    assign timer_int = timer_int_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// tb/tb_data_sram_resp.sv - scoreboard bench for data_sram_resp
module tb_data_sram_resp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] daddr;
    logic        dce;
    logic [3:0]  we;
    logic [31:0] din;
    logic [31:0] dm;
    logic [15:0] switch_in;
    logic [15:0] led;
    logic        timer_int;

    int tests_run = 0;
    int fails     = 0;

    logic [31:0] exp_q [$];
    string       name_q [$];

    localparam logic [31:0] A_LED  = 32'hBFAF_F000;
    localparam logic [31:0] A_SW   = 32'hBFAF_F004;
    localparam logic [31:0] A_CNT  = 32'hBFAF_F008;
    localparam logic [31:0] A_CMP  = 32'hBFAF_F00C;
    localparam logic [31:0] A_CTRL = 32'hBFAF_F010;

    data_sram_resp #(.ADDR_W(10), .TIMER_RST_CMP(32'hFFFF_FFFF)) dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .daddr       (daddr),
        .dce         (dce),
        .we          (we),
        .din         (din),
        .dm          (dm),
        .switch      (switch_in),
        .led         (led),
        .timer_int   (timer_int)
    );

    always #5 clk = ~clk;

    // Scoreboard: every read accepted at an edge pops one expected value
    always @(posedge clk) begin
        logic        was_rd;
        logic [31:0] e;
        string       n;
        was_rd = rst_n && dce && (we == 4'd0);
        #1;
        if (was_rd) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_underflow: read with no expected entry, dm=%h", dm);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (dm !== e) begin
                    fails++;
                    $display("FAIL %s: dm=%h expected=%h", n, dm, e);
                end
            end
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] w, input logic ce);
        daddr = a;
        din   = d;
        we    = w;
        dce   = ce;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        drive(a, d, w, 1'b1);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
        drive(a, 32'h0, 4'h0, 1'b1);
    endtask

    task automatic idle();
        drive(32'h0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wr(32'h10, 32'hDEAD_BEEF, 4'hF);
        wr(A_LED, 32'hFFFF_FFFF, 4'hF);
        rst_n = 1'b1;
        idle();
        tests_run++;
        if (dm !== 32'h0) begin
            fails++; $display("FAIL reset_dm: dm=%h expected=00000000", dm);
        end
        tests_run++;
        if (led !== 16'h0) begin
            fails++; $display("FAIL reset_led: led=%h expected=0000", led);
        end
        tests_run++;
        if (timer_int !== 1'b0) begin
            fails++; $display("FAIL reset_int: timer_int=%b expected=0", timer_int);
        end
        rd(A_CNT, 32'h0, "reset_count");
        rd(A_CMP, 32'hFFFF_FFFF, "reset_compare");
    endtask

    task automatic test_ram_lanes();
        wr(32'h10, 32'h1122_3344, 4'hF);
        wr(32'h10, 32'hAA00_00BB, 4'h9);
        rd(32'h10, 32'hAA22_33BB, "ram_lanes");
        rd(32'h1010, 32'hAA22_33BB, "ram_alias");
    endtask

    task automatic test_read_first();
        wr(32'h20, 32'h5, 4'hF);
        rd(32'h20, 32'h5, "read_after_write");
        for (int i = 0; i < 3; i++) begin
            idle();
            tests_run++;
            if (dm !== 32'h5) begin
                fails++; $display("FAIL idle_hold_%0d: dm=%h expected=00000005", i, dm);
            end
        end
    endtask

    task automatic test_mmio();
        wr(A_LED, 32'hFFFF_A5A5, 4'hF);
        tests_run++;
        if (led !== 16'hA5A5) begin
            fails++; $display("FAIL led_write: led=%h expected=a5a5", led);
        end
        rd(A_LED, 32'h0000_A5A5, "led_read");
        wr(A_LED, 32'h0000_3C00, 4'h2);
        tests_run++;
        if (led !== 16'h3CA5) begin
            fails++; $display("FAIL led_lane: led=%h expected=3ca5", led);
        end
        switch_in = 16'h1234;
        wr(A_SW, 32'hFFFF_FFFF, 4'hF);
        rd(A_SW, 32'h0000_1234, "switch_read");
        rd(32'hBFAF_F0FC, 32'h0, "unmapped_read");
    endtask

    task automatic test_timer();
        wr(A_CMP, 32'd5, 4'hF);
        wr(A_CNT, 32'd0, 4'hF);
        wr(A_CTRL, 32'd1, 4'hF);
        for (int i = 1; i <= 7; i++) begin
            idle();
            tests_run++;
            if (timer_int !== (i == 7)) begin
                fails++; $display("FAIL timer_rise_%0d: timer_int=%b expected=%b", i, timer_int, i == 7);
            end
        end
        wr(A_CTRL, 32'd3, 4'hF);
        tests_run++;
        if (timer_int !== 1'b1) begin
            fails++; $display("FAIL timer_clr_edge: timer_int=%b expected=1", timer_int);
        end
        idle();
        tests_run++;
        if (timer_int !== 1'b0) begin
            fails++; $display("FAIL timer_cleared: timer_int=%b expected=0", timer_int);
        end
        wr(A_CMP, 32'h22, 4'hF);
        wr(A_CNT, 32'h20, 4'hF);
        idle();
        idle();
        idle();
        wr(A_CTRL, 32'd0, 4'hF);
        rd(A_CTRL, 32'd2, "ctrl_pend_masked");
        tests_run++;
        if (timer_int !== 1'b0) begin
            fails++; $display("FAIL timer_masked: timer_int=%b expected=0", timer_int);
        end
    endtask

    task automatic test_wrap_collision();
        wr(A_CTRL, 32'd1, 4'hF);
        wr(A_CNT, 32'hFFFF_FFFF, 4'hF);
        idle();
        idle();
        rd(A_CNT, 32'h1, "count_wrap");
        wr(A_CNT, 32'h100, 4'hF);
        rd(A_CNT, 32'h100, "count_write_wins");
        rd(A_CNT, 32'h101, "count_inc_after");
        wr(A_CTRL, 32'd3, 4'hF);
        wr(A_CMP, 32'h300, 4'hF);
        wr(A_CNT, 32'h2FF, 4'hF);
        rd(A_CTRL, 32'd1, "pend_cleared");
        wr(A_CTRL, 32'd3, 4'hF);
        rd(A_CTRL, 32'd3, "pend_set_wins");
    endtask

    initial begin
        rst_n     = 1'b0;
        daddr     = 32'h0;
        dce       = 1'b0;
        we        = 4'h0;
        din       = 32'h0;
        switch_in = 16'h0;
        @(negedge clk);
        test_reset();
        test_ram_lanes();
        test_read_first();
        test_mmio();
        test_timer();
        test_wrap_collision();
        idle();
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL sb_leftover: %0d entries expected=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/data_sram_resp.md
# data_sram_resp

Data-side responder for the CPU core's SRAM-style data port (`daddr`/`dce`/`we`/`din`/`dm`). It sits in the SoC top beside the core. It serves a word-addressed data RAM with byte-lane writes and one-cycle registered reads, and decodes a small MMIO window holding LED, switch, and interval-timer registers. The timer interrupt output drives one bit of the core's `int[5:0]`.

## Interface
Parameters:
- `ADDR_W`, default 10: RAM word-address width; RAM holds 2^ADDR_W 32-bit words.
- `TIMER_RST_CMP`, default 32'hFFFF_FFFF: reset value of the COMPARE register.

Ports:
- `cpu_clk_50M`, input, 1: sole clock; all state updates on the rising edge.
- `cpu_rst_n`, input, 1: reset, synchronous, active-low.
- `daddr`, input, 32: byte address from the core; bits [1:0] are ignored.
- `dce`, input, 1: access enable.
- `we`, input, 4: byte-lane write enables; `we[i]` writes `din[8i+7:8i]`; `we==0` with `dce` is a read.
- `din`, input, 32: write data.
- `dm`, output, 32: registered read data.
- `switch`, input, 16: board switches, sampled on read.
- `led`, output, 16: LED register bits [15:0].
- `timer_int`, output, 1: level timer interrupt.

## Operation
- Decode: MMIO when `daddr[31:16]==16'hBFAF`. Otherwise the access goes to RAM at word index `daddr[ADDR_W+1:2]`; upper bits are ignored, so addresses alias and wrap.
- MMIO map, by offset `daddr[15:0]`:
  - F000 LED: RW, bits [15:0] stored, upper bits read as 0.
  - F004 SWITCH: RO, returns `{16'b0, switch}`; writes are ignored.
  - F008 COUNT: RW.
  - F00C COMPARE: RW.
  - F010 CTRL: bit0 EN (RW); bit1 PEND (read; writing 1 clears it); other bits read as 0.
  - Any other offset reads 0 and ignores writes.
- Byte lanes: all RW registers honour `we` per lane, the same as RAM.
- Write: on an edge with `dce=1` and `we!=0`, the enabled lanes of the target are updated. `dm` is not updated on a write cycle and holds its previous value.
- Read: on an edge with `dce=1` and `we==0`, `dm` loads the target's pre-edge contents (read-first).
- Idle: with `dce=0`, `dm` holds its value and nothing is written.
- Timer:
  - COUNT increments by 1 every cycle while EN=1 and wraps from 0xFFFF_FFFF to 0.
  - When EN=1 and pre-edge COUNT==COMPARE, PEND is set on that edge.
  - `timer_int` is registered and equals PEND & EN. Clearing EN masks it without clearing PEND.
- Priorities within one edge:
  - A CPU write to COUNT overrides the increment.
  - PEND set overrides a write-1-to-clear in the same cycle.
  - A CTRL write updates EN; the match test uses the pre-edge EN.

## Timing
- Reset values, applied on a `cpu_rst_n=0` edge: `dm`=0, `led`=0, COUNT=0, COMPARE=`TIMER_RST_CMP`, CTRL=0, `timer_int`=0. RAM contents are not reset.
- Reset asserted mid-access aborts that access: no write occurs and `dm` becomes 0.
- Read latency is 1: an address presented in cycle N gives data on `dm` in cycle N+1. This matches the core sampling `dm` in WB, one stage after MEM.
- Writes take effect at the edge ending cycle N. A read of the same address in N+1 returns the new data; a read in cycle N itself returns the old data.
- `timer_int` asserts one cycle after the edge that sets PEND, i.e. 2 cycles after COUNT==COMPARE is first visible.
- There are no stalls and no handshake; every enabled access completes in one cycle.

## Test plan
1. Reset: hold `cpu_rst_n=0` for 2 edges with `dce=1`, `we=F`. Then read 0xBFAF_F008 -> `dm`=0; `led`=0; `timer_int`=0; read 0xBFAF_F00C -> 0xFFFF_FFFF.
2. RAM byte lanes: write 0x1122_3344 to 0x0000_0010 with `we=F`, then 0xAA00_00BB with `we=9`. Read 0x10 -> `dm`=0xAA22_33BB one cycle later. With ADDR_W=10, read 0x1010 (alias) -> same value.
3. Read-first: back-to-back write 0x5 then read to the same address; the read in the following cycle returns 0x5. Keep `dce=0` for 3 cycles -> `dm` stays 0x5.
4. MMIO:
   - Write 0xFFFF_A5A5 to F000 -> `led`=0xA5A5; read F000 -> 0x0000_A5A5.
   - Set `switch`=0x1234 and read F004 -> 0x0000_1234.
   - Read F0FC -> 0.
5. Timer:
   - Write COMPARE=5 and COUNT=0, then CTRL=1. PEND sets when COUNT==5; `timer_int`=1 one cycle later.
   - Write CTRL=3 -> `timer_int` drops the next cycle.
   - Write CTRL=0 while PEND=1 -> `timer_int`=0 and reading CTRL returns 2.
6. Wrap and collision:
   - Write COUNT=0xFFFF_FFFF with EN=1 -> COUNT reads 0x0000_0001 two cycles later.
   - Write COUNT=0x100 with EN=1 -> COUNT=0x100 at that edge and 0x101 one edge later.
   - Issue a write-1-to-clear PEND in the same cycle as a COUNT==COMPARE match -> PEND stays 1.
